// File: rtl/seq_chunk_adder_pkg.sv
// Shared definitions for the multi-cycle chunked add/subtract unit:
// FSM state encodings and the chunk-index width helper.
package seq_chunk_adder_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_BUSY = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  // Index counter needs at least one bit even when there is a single chunk.
  function automatic int idx_width(input int n_chunk);
    return (n_chunk > 1) ? $clog2(n_chunk) : 1;
  endfunction

endpackage

// File: rtl/seq_chunk_adder_chunk.sv
// Combinational W-bit ripple slice: sum, carry out, and the carry into the
// slice MSB (needed for signed-overflow detection on the final slice).
module chunk_adder #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout,
  output logic         c_msb
);

  logic [W:0] w_sum;

  assign w_sum = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
  assign s     = w_sum[W-1:0];
  assign cout  = w_sum[W];
  // Sum bit = a ^ b ^ carry-in, so the MSB carry-in falls out of the sum bit.
  assign c_msb = w_sum[W-1] ^ a[W-1] ^ b[W-1];

endmodule

// File: rtl/seq_chunk_adder.sv
// Multi-cycle two's-complement add/subtract: one CHUNK-bit slice per clock
// through a single time-multiplexed chunk_adder, with valid/ready on both sides.
module seq_chunk_adder
  import seq_chunk_adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW     = idx_width(NCHUNK);
  localparam logic [IW-1:0]    LAST_IDX   = IW'(NCHUNK - 1);
  localparam logic [WIDTH-1:0] SLICE_MASK = WIDTH'({CHUNK{1'b1}});

  if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_params
    $error("seq_chunk_adder: CHUNK must divide WIDTH and satisfy 1 <= CHUNK <= WIDTH");
  end

  state_t           r_state;
  logic [IW-1:0]    r_idx;
  logic             r_carry;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_s;
  logic             r_cout;
  logic             r_ovf;

  logic [31:0]      w_base;
  logic [CHUNK-1:0] w_a_slice;
  logic [CHUNK-1:0] w_b_slice;
  logic [CHUNK-1:0] w_sum;
  logic             w_cout;
  logic             w_c_msb;
  logic             w_last;

  assign w_base    = 32'(r_idx) * 32'(CHUNK);
  assign w_a_slice = CHUNK'(r_a >> w_base);
  assign w_b_slice = CHUNK'(r_b >> w_base);
  assign w_last    = (r_idx == LAST_IDX);

  chunk_adder #(.W(CHUNK)) u_chunk (
    .a     (w_a_slice),
    .b     (w_b_slice),
    .cin   (r_carry),
    .s     (w_sum),
    .cout  (w_cout),
    .c_msb (w_c_msb)
  );

  // NOTE: every register here, operand copies included, is plain flops with
  // an async reset and non-blocking updates, so no partial result survives reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_s     <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= sub ? ~b : b;
            r_carry <= sub | cin;
            r_idx   <= '0;
            r_s     <= '0;
            r_state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          r_s     <= (r_s & ~(SLICE_MASK << w_base)) | (WIDTH'(w_sum) << w_base);
          r_carry <= w_cout;
          if (w_last) begin
            r_cout  <= w_cout;
            r_ovf   <= w_c_msb ^ w_cout;
            r_idx   <= '0;
            r_state <= ST_DONE;
          end else begin
            r_idx <= r_idx + IW'(1);
          end
        end
        ST_DONE: begin
          if (out_ready) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign s         = r_s;
  assign cout      = r_cout;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Self-checking bench: five instances (CHUNK = 1, 4, 8, 16, 32) driven by a
// directed vector table, multi-cycle corner sequences and random operations.
module tb_seq_chunk_adder;

  localparam int W  = 32;
  localparam int NI = 5;
  localparam int K8 = 2;

  function automatic int chunk_of(input int k);
    case (k)
      0:       return 1;
      1:       return 4;
      2:       return 8;
      3:       return 16;
      default: return 32;
    endcase
  endfunction

  logic          clk   = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid_v  [NI];
  logic          in_ready_v  [NI];
  logic [W-1:0]  a_v         [NI];
  logic [W-1:0]  b_v         [NI];
  logic          cin_v       [NI];
  logic          sub_v       [NI];
  logic          out_valid_v [NI];
  logic          out_ready_v [NI];
  logic [W-1:0]  s_v         [NI];
  logic          cout_v      [NI];
  logic          ovf_v       [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    seq_chunk_adder #(.WIDTH(W), .CHUNK(chunk_of(g))) u_dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid_v[g]),
      .in_ready  (in_ready_v[g]),
      .a         (a_v[g]),
      .b         (b_v[g]),
      .cin       (cin_v[g]),
      .sub       (sub_v[g]),
      .out_valid (out_valid_v[g]),
      .out_ready (out_ready_v[g]),
      .s         (s_v[g]),
      .cout      (cout_v[g]),
      .ovf       (ovf_v[g])
    );
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain unsigned/signed arithmetic on the whole word.
  function automatic void ref_model(input logic [31:0] a, input logic [31:0] b,
                                    input logic cin, input logic sub,
                                    output logic [31:0] s, output logic co,
                                    output logic ov);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint r;
    longint unsigned u;
    if (sub) begin
      s  = a - b;
      co = (a >= b);
      r  = sa - sb;
    end else begin
      u  = longint'(a) + longint'(b) + longint'(cin);
      s  = u[31:0];
      co = u[32];
      r  = sa + sb + longint'(cin);
    end
    ov = (r > 64'sd2147483647) || (r < -64'sd2147483648);
  endfunction

  task automatic accept(input int k, input logic [31:0] a, input logic [31:0] b,
                        input logic cin, input logic sub);
    int t = 0;
    @(negedge clk);
    while (!in_ready_v[k] && t < 200) begin
      @(negedge clk);
      t++;
    end
    check($sformatf("in_ready_at_accept k%0d", k), 64'(in_ready_v[k]), 64'd1);
    a_v[k] = a; b_v[k] = b; cin_v[k] = cin; sub_v[k] = sub;
    in_valid_v[k] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    // Scramble operands after the accepting edge; they must have no effect.
    in_valid_v[k] = 1'b0;
    a_v[k] = $urandom; b_v[k] = $urandom;
    cin_v[k] = 1'($urandom); sub_v[k] = ~sub;
  endtask

  // Called at a negedge; counts edges until out_valid is seen.
  task automatic wait_valid(input int k, input bit poke, output int lat);
    lat = 0;
    while (!out_valid_v[k] && lat < 100) begin
      if (poke) out_ready_v[k] = 1'($urandom);
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    out_ready_v[k] = 1'b0;
    check($sformatf("out_valid_within_bound k%0d", k), 64'(out_valid_v[k]), 64'd1);
  endtask

  task automatic release_result(input int k);
    out_ready_v[k] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready_v[k] = 1'b0;
    check($sformatf("in_ready_after_release k%0d", k), 64'(in_ready_v[k]), 64'd1);
    check($sformatf("out_valid_after_release k%0d", k), 64'(out_valid_v[k]), 64'd0);
  endtask

  task automatic run_op(input int k, input logic [31:0] a, input logic [31:0] b,
                        input logic cin, input logic sub, input bit poke,
                        output logic [31:0] s, output logic co, output logic ov,
                        output int lat);
    accept(k, a, b, cin, sub);
    wait_valid(k, poke, lat);
    s  = s_v[k];
    co = cout_v[k];
    ov = ovf_v[k];
    release_result(k);
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic [31:0] s;
    logic        co;
    logic        ov;
  } vec_t;

  vec_t vecs[7];

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] got_s, exp_s;
    logic        got_co, got_ov, exp_co, exp_ov;
    int          lat;

    vecs[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    vecs[1] = '{32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
    vecs[2] = '{32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1, 32'h0000_0002, 1'b1, 1'b0};
    vecs[3] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
    vecs[4] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
    vecs[5] = '{32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0, 1'b0};
    vecs[6] = '{32'h0000_000F, 32'h0000_0001, 1'b1, 1'b0, 32'h0000_0011, 1'b0, 1'b0};

    for (int k = 0; k < NI; k++) begin
      in_valid_v[k] = 1'b0; out_ready_v[k] = 1'b0;
      a_v[k] = '0; b_v[k] = '0; cin_v[k] = 1'b0; sub_v[k] = 1'b0;
    end

    // Reset state, both during and just after reset.
    repeat (3) @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      check($sformatf("rst in_ready k%0d", k), 64'(in_ready_v[k]), 64'd1);
      check($sformatf("rst out_valid k%0d", k), 64'(out_valid_v[k]), 64'd0);
      check($sformatf("rst s k%0d", k), 64'(s_v[k]), 64'd0);
      check($sformatf("rst cout k%0d", k), 64'(cout_v[k]), 64'd0);
      check($sformatf("rst ovf k%0d", k), 64'(ovf_v[k]), 64'd0);
    end
    reset = 1'b0;
    @(negedge clk);
    check("post_rst in_ready", 64'(in_ready_v[K8]), 64'd1);

    // Directed table on every chunk size; latency must equal NCHUNK.
    for (int k = 0; k < NI; k++) begin
      for (int i = 0; i < 7; i++) begin
        run_op(k, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, 1'b0,
               got_s, got_co, got_ov, lat);
        check($sformatf("vec%0d s k%0d", i, k), 64'(got_s), 64'(vecs[i].s));
        check($sformatf("vec%0d cout k%0d", i, k), 64'(got_co), 64'(vecs[i].co));
        check($sformatf("vec%0d ovf k%0d", i, k), 64'(got_ov), 64'(vecs[i].ov));
        check($sformatf("vec%0d latency k%0d", i, k), 64'(lat), 64'(W / chunk_of(k)));
      end
    end

    // Backpressure: result held while new bundles are offered and refused.
    accept(K8, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    wait_valid(K8, 1'b0, lat);
    for (int c = 0; c < 10; c++) begin
      in_valid_v[K8] = 1'b1;
      a_v[K8] = $urandom; b_v[K8] = $urandom;
      cin_v[K8] = 1'($urandom); sub_v[K8] = 1'($urandom);
      @(posedge clk);
      @(negedge clk);
      check($sformatf("stall%0d s", c), 64'(s_v[K8]), 64'h8000_0000);
      check($sformatf("stall%0d cout", c), 64'(cout_v[K8]), 64'd0);
      check($sformatf("stall%0d ovf", c), 64'(ovf_v[K8]), 64'd1);
      check($sformatf("stall%0d in_ready", c), 64'(in_ready_v[K8]), 64'd0);
      check($sformatf("stall%0d out_valid", c), 64'(out_valid_v[K8]), 64'd1);
    end
    a_v[K8] = 32'h1234_5678; b_v[K8] = 32'h1111_1111;
    cin_v[K8] = 1'b0; sub_v[K8] = 1'b0;
    out_ready_v[K8] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready_v[K8] = 1'b0;
    check("bp in_ready after pulse", 64'(in_ready_v[K8]), 64'd1);
    check("bp out_valid after pulse", 64'(out_valid_v[K8]), 64'd0);
    @(posedge clk);
    @(negedge clk);
    in_valid_v[K8] = 1'b0;
    check("bp new bundle accepted", 64'(in_ready_v[K8]), 64'd0);
    wait_valid(K8, 1'b0, lat);
    check("bp new latency", 64'(lat), 64'd4);
    check("bp new s", 64'(s_v[K8]), 64'h2345_6789);
    release_result(K8);

    // Asynchronous reset between BUSY edges 2 and 3.
    accept(K8, 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2;
    check("midop busy before reset", 64'(in_ready_v[K8]), 64'd0);
    reset = 1'b1;
    #1;
    check("midop out_valid", 64'(out_valid_v[K8]), 64'd0);
    check("midop in_ready", 64'(in_ready_v[K8]), 64'd1);
    check("midop s", 64'(s_v[K8]), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    run_op(K8, 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 1'b0, got_s, got_co, got_ov, lat);
    check("after_reset s", 64'(got_s), 64'h2345_6789);
    check("after_reset latency", 64'(lat), 64'd4);

    // Random operations against the reference model, with out_ready poked early.
    for (int k = 0; k < NI; k++) begin
      for (int i = 0; i < 200; i++) begin
        logic [31:0] ra, rb;
        logic        rc, rs;
        ra = pick_operand(); rb = pick_operand();
        rc = 1'($urandom);   rs = 1'($urandom);
        ref_model(ra, rb, rc, rs, exp_s, exp_co, exp_ov);
        run_op(k, ra, rb, rc, rs, 1'b1, got_s, got_co, got_ov, lat);
        check($sformatf("rnd%0d s k%0d a=%h b=%h sub=%0d", i, k, ra, rb, rs),
              64'(got_s), 64'(exp_s));
        check($sformatf("rnd%0d cout k%0d", i, k), 64'(got_co), 64'(exp_co));
        check($sformatf("rnd%0d ovf k%0d", i, k), 64'(got_ov), 64'(exp_ov));
        check($sformatf("rnd%0d latency k%0d", i, k), 64'(lat), 64'(W / chunk_of(k)));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
